// File: rtl/square_detector_if.sv
// Pixel-stream input and square-result output bundle between the VGA timing
// path (master) and the square detector (slave).
interface square_detector_if;
    logic [7:0]  pixel_in;
    logic        pixel_valid;
    logic [12:0] VGA_H_CNT;
    logic [12:0] VGA_V_CNT;
    logic        frame_start;
    logic [10:0] square_x;
    logic [10:0] square_y;
    logic [10:0] square_size;
    logic        square_detected;
    logic        result_valid;

    modport master (
        output pixel_in, pixel_valid, VGA_H_CNT, VGA_V_CNT, frame_start,
        input  square_x, square_y, square_size, square_detected, result_valid
    );

    modport slave (
        input  pixel_in, pixel_valid, VGA_H_CNT, VGA_V_CNT, frame_start,
        output square_x, square_y, square_size, square_detected, result_valid
    );
endinterface

// File: rtl/square_detector.sv
// Per-frame bounding box of bright pixels, square classification at each frame
// boundary, and a frame-count hysteresis filter on the detection result.
module square_detector #(
    parameter int unsigned THRESHOLD     = 200,
    parameter int unsigned MIN_PIXELS    = 64,
    parameter int unsigned MIN_SIZE      = 8,
    parameter int unsigned MAX_SIZE      = 400,
    parameter int unsigned TOL           = 4,
    parameter int unsigned STABLE_FRAMES = 3,
    parameter int unsigned LOSS_FRAMES   = 2
) (
    input  logic             VGA_CLK,
    input  logic             RST,
    square_detector_if.slave bus
);

    localparam int unsigned CW = 11;
    localparam int unsigned DW = 12;
    localparam int unsigned HW = 20;
    localparam int unsigned FW = 8;

    localparam logic [7:0]    THRESH_L   = 8'(THRESHOLD);
    localparam logic [HW-1:0] MIN_PIX_L  = HW'(MIN_PIXELS);
    localparam logic [HW-1:0] CNT_MAX    = {HW{1'b1}};
    localparam logic [DW-1:0] MIN_SZ_L   = DW'(MIN_SIZE);
    localparam logic [DW-1:0] MAX_SZ_L   = DW'(MAX_SIZE);
    localparam logic [DW-1:0] TOL_L      = DW'(TOL);
    localparam logic [FW-1:0] STABLE_L   = FW'(STABLE_FRAMES);
    localparam logic [FW-1:0] LOSS_L     = FW'(LOSS_FRAMES);
    localparam logic [CW-1:0] COORD_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EVAL  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_nxt;

    logic          acc_restart_c;
    logic          acc_en_c;
    logic          snap_en_c;
    logic          eval_c;

    logic          hit_c;
    logic [CW-1:0] px_x_c;
    logic [CW-1:0] px_y_c;

    logic [CW-1:0] min_x_q, min_y_q, max_x_q, max_y_q;
    logic [HW-1:0] cnt_q;
    logic [CW-1:0] min_x_nxt, min_y_nxt, max_x_nxt, max_y_nxt;
    logic [HW-1:0] cnt_nxt;

    logic [CW-1:0] snap_min_x, snap_min_y, snap_max_x, snap_max_y;
    logic [HW-1:0] snap_cnt;

    logic [DW-1:0] w_c;
    logic [DW-1:0] h_c;
    logic [DW-1:0] diff_c;
    logic [CW-1:0] size_c;
    logic          sq_c;

    logic [FW-1:0] stable_q, stable_nxt;
    logic [FW-1:0] loss_q, loss_nxt;
    logic          det_q, det_nxt;
    logic          upd_coord_c;

    logic [CW-1:0] square_x_q;
    logic [CW-1:0] square_y_q;
    logic [CW-1:0] square_size_q;
    logic          result_valid_q;

    // Bright pixel inside the 2048x2048 addressable area
    assign hit_c  = bus.pixel_valid && (bus.pixel_in >= THRESH_L)
                    && (bus.VGA_H_CNT[12:11] == 2'b00)
                    && (bus.VGA_V_CNT[12:11] == 2'b00);
    assign px_x_c = bus.VGA_H_CNT[CW-1:0];
    assign px_y_c = bus.VGA_V_CNT[CW-1:0];

    always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next state plus accumulator/snapshot/evaluation strobes
    always_comb begin
        state_nxt     = state_q;
        acc_restart_c = 1'b0;
        acc_en_c      = 1'b0;
        snap_en_c     = 1'b0;
        eval_c        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.frame_start) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                acc_en_c = 1'b1;
                if (bus.frame_start) begin
                    state_nxt     = EVAL;
                    acc_restart_c = 1'b1;
                    snap_en_c     = 1'b1;
                end
            end
            EVAL: begin
                acc_en_c  = 1'b1;
                eval_c    = 1'b1;
                state_nxt = ACCUM;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // On a frame boundary the boundary pixel starts the new frame's box
    always_comb begin
        min_x_nxt = acc_restart_c ? COORD_MAX  : min_x_q;
        min_y_nxt = acc_restart_c ? COORD_MAX  : min_y_q;
        max_x_nxt = acc_restart_c ? '0         : max_x_q;
        max_y_nxt = acc_restart_c ? '0         : max_y_q;
        cnt_nxt   = acc_restart_c ? '0         : cnt_q;
        if (acc_en_c && hit_c) begin
            if (px_x_c < min_x_nxt) min_x_nxt = px_x_c;
            if (px_y_c < min_y_nxt) min_y_nxt = px_y_c;
            if (px_x_c > max_x_nxt) max_x_nxt = px_x_c;
            if (px_y_c > max_y_nxt) max_y_nxt = px_y_c;
            if (cnt_nxt != CNT_MAX) cnt_nxt = cnt_nxt + HW'(1);
        end
    end

    always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST) begin
            min_x_q <= COORD_MAX;
            min_y_q <= COORD_MAX;
            max_x_q <= '0;
            max_y_q <= '0;
            cnt_q   <= '0;
        end else begin
            min_x_q <= min_x_nxt;
            min_y_q <= min_y_nxt;
            max_x_q <= max_x_nxt;
            max_y_q <= max_y_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST) begin
            snap_min_x <= COORD_MAX;
            snap_min_y <= COORD_MAX;
            snap_max_x <= '0;
            snap_max_y <= '0;
            snap_cnt   <= '0;
        end else if (snap_en_c) begin
            snap_min_x <= min_x_q;
            snap_min_y <= min_y_q;
            snap_max_x <= max_x_q;
            snap_max_y <= max_y_q;
            snap_cnt   <= cnt_q;
        end
    end

    // Square classification of the snapshot; an empty frame wraps w/h so it is gated explicitly
    always_comb begin
        w_c    = DW'(snap_max_x) - DW'(snap_min_x) + DW'(1);
        h_c    = DW'(snap_max_y) - DW'(snap_min_y) + DW'(1);
        diff_c = (w_c >= h_c) ? (w_c - h_c) : (h_c - w_c);
        size_c = (w_c >= h_c) ? CW'(w_c) : CW'(h_c);
        sq_c   = (snap_cnt != '0) && (snap_cnt >= MIN_PIX_L)
                 && (w_c >= MIN_SZ_L) && (w_c <= MAX_SZ_L)
                 && (h_c >= MIN_SZ_L) && (h_c <= MAX_SZ_L)
                 && (diff_c <= TOL_L);
    end

    // Hysteresis: saturating streak counters for square and non-square frames
    always_comb begin
        stable_nxt = stable_q;
        loss_nxt   = loss_q;
        det_nxt    = det_q;
        if (sq_c) begin
            loss_nxt   = '0;
            stable_nxt = (stable_q >= STABLE_L) ? STABLE_L : stable_q + FW'(1);
            if (stable_nxt == STABLE_L) det_nxt = 1'b1;
        end else begin
            stable_nxt = '0;
            loss_nxt   = (loss_q >= LOSS_L) ? LOSS_L : loss_q + FW'(1);
            if (loss_nxt == LOSS_L) det_nxt = 1'b0;
        end
        upd_coord_c = sq_c && det_nxt;
    end

    always_ff @(posedge VGA_CLK or posedge RST) begin
        if (RST) begin
            stable_q       <= '0;
            loss_q         <= '0;
            det_q          <= 1'b0;
            square_x_q     <= '0;
            square_y_q     <= '0;
            square_size_q  <= '0;
            result_valid_q <= 1'b0;
        end else begin
            result_valid_q <= eval_c;
            if (eval_c) begin
                stable_q <= stable_nxt;
                loss_q   <= loss_nxt;
                det_q    <= det_nxt;
                if (upd_coord_c) begin
                    square_x_q    <= snap_min_x;
                    square_y_q    <= snap_min_y;
                    square_size_q <= size_c;
                end
            end
        end
    end

    assign bus.square_x        = square_x_q;
    assign bus.square_y        = square_y_q;
    assign bus.square_size     = square_size_q;
    assign bus.square_detected = det_q;
    assign bus.result_valid    = result_valid_q;

endmodule
